instr_decode: RTL and testbench
===============================

INSTR_DECODE -- requirements
Module: instr_decode

Interface
REQ-001 SHALL have parameter DSIZE, default `DSIZE (32), the width of the immediate output.
REQ-002 SHALL have parameter DEPTH, default 2, the output buffer entry count.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  the instr input is valid.
REQ-006 in_ready  output  1  the decoder accepts instr this cycle.
REQ-007 instr  input  32  raw RV32 instruction word.
REQ-008 out_valid  output  1  the buffer head holds a decoded instruction.
REQ-009 out_ready  input  1  the execute stage consumes the head this cycle.
REQ-010 instr_code  output  4  the shared ALU code: ADD, MUL, ADDI, LW, SW or BNE.
REQ-011 rs1, rs2, rd  output  5 each  register indices.
REQ-012 imm  output  DSIZE  the sign-extended immediate.
REQ-013 illegal  output  1  the head is an unsupported encoding.
REQ-014 wb_valid  input  1  a writeback is retiring this cycle.
REQ-015 wb_rd  input  5  the destination being retired.

Function
REQ-016 Decode SHALL use opcode, funct3 and funct7, as follows:
- opcode 0110011, funct3 000: funct7 0000000 -> ADD; funct7 0000001 -> MUL.
- opcode 0010011, funct3 000 -> ADDI.
- opcode 0000011, funct3 010 -> LW.
- opcode 0100011, funct3 010 -> SW.
- opcode 1100011, funct3 001 -> BNE.
- Any other encoding -> illegal=1, instr_code=ADD, imm=0.
REQ-017 imm SHALL be built per instruction type:
- I-type (ADDI, LW): sext(instr[31:20]).
- S-type (SW): sext({instr[31:25],instr[11:7]}).
- B-type (BNE): sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}).
- R-type (ADD, MUL): 0.
REQ-018 rd SHALL be forced to 0 for SW, BNE and illegal encodings.
REQ-019 A 32-bit busy scoreboard SHALL track pending writes; busy[0] is constant 0.
REQ-020 Hazard SHALL be asserted when any of the following holds:
- busy[rs1] is set.
- busy[rs2] is set, for ADD, MUL, SW or BNE.
- busy[rd] is set, with rd nonzero (WAW).
REQ-021 Hazard SHALL evaluate against the scoreboard after applying the same-cycle wb clear, so a retiring register does not stall.
REQ-022 in_ready SHALL equal (buffer not full, or out_ready with out_valid) AND NOT hazard.
REQ-023 Accept SHALL be in_valid and in_ready; on accept, the decoded fields enter the buffer tail and busy[rd] is set for a legal rd≠0.
REQ-024 If wb clear and accept set target the same rd in one cycle, set SHALL win.
REQ-025 Latency SHALL be 1 cycle: an instruction accepted in cycle N into an empty buffer shows out_valid in N+1.
REQ-026 The buffer SHALL be FIFO-ordered; simultaneous push and pop are legal, including when full.
REQ-027 While out_valid=1 and out_ready=0, all out fields SHALL stay stable.
REQ-028 wb_valid with wb_rd=0, or with a non-busy register, SHALL have no effect.
REQ-029 Illegal instructions SHALL pass through in order with illegal=1 and set no busy bit.

Reset
REQ-030 While rst=1, regardless of clk, the following SHALL hold:
- The buffer is empty and the busy vector is 0.
- out_valid=0, instr_code=0, rs1=rs2=rd=0, imm=0, illegal=0.
- in_ready=0.
REQ-031 Assertion of rst mid-operation SHALL discard all buffered entries and busy bits; nothing is replayed.
REQ-032 After rst deasserts, in_ready SHALL rise within one cycle.

Structure
REQ-033 The shared define file SHALL hold DSIZE, the six 4-bit instr_code constants and the RV32 opcode/funct constants; codes are taken from there, never re-encoded locally.
REQ-034 The busy vector, its clear/set logic and its hazard lookup SHALL form sub-module reg_scoreboard; decode and buffer stay in instr_decode.

Verification
REQ-035 ADDI x1,x0,-5 (0xFFB00093) with an empty buffer and out_ready=1 -> next cycle: instr_code=ADDI, rd=1, imm=0xFFFFFFFB, illegal=0; busy[1]=1.
REQ-036 ADD x2,x1,x1 issued right after REQ-035 without wb -> in_ready=0 until wb_valid=1, wb_rd=1; accepted in that same wb cycle.
REQ-037 SW x3,-4(x2) (0xFE312E23) -> imm=0xFFFFFFFC, rd=0, no busy bit set.
REQ-038 BNE x0,x0,-8 (0xFE001CE3) -> imm=0xFFFFFFF8, instr_code=BNE.
REQ-039 out_ready=0 with three legal independent instructions -> two accepted, third stalls; heads stay stable; releasing out_ready drains them in order.
REQ-040 Instruction 0x00000000 -> illegal=1; rst asserted asynchronously mid-stream -> out_valid=0 and busy=0 immediately.

Source files
------------

// File: rtl/instr_decode_pkg.sv
// instr_decode_pkg: shared widths, ALU codes and RV32 opcode/funct constants for the decoder.
// Revision 1.0
`default_nettype none

`ifndef DSIZE
`define DSIZE 32
`endif

package instr_decode_pkg;

  localparam logic [3:0] c_CODE_ADD  = 4'd0;
  localparam logic [3:0] c_CODE_MUL  = 4'd1;
  localparam logic [3:0] c_CODE_ADDI = 4'd2;
  localparam logic [3:0] c_CODE_LW   = 4'd3;
  localparam logic [3:0] c_CODE_SW   = 4'd4;
  localparam logic [3:0] c_CODE_BNE  = 4'd5;

  localparam logic [6:0] c_OP_REG    = 7'b0110011;
  localparam logic [6:0] c_OP_IMM    = 7'b0010011;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;

  localparam logic [2:0] c_F3_ADD    = 3'b000;
  localparam logic [2:0] c_F3_LW     = 3'b010;
  localparam logic [2:0] c_F3_SW     = 3'b010;
  localparam logic [2:0] c_F3_BNE    = 3'b001;

  localparam logic [6:0] c_F7_BASE   = 7'b0000000;
  localparam logic [6:0] c_F7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_X = 3'd4
  } fmt_e;

endpackage

`default_nettype wire

// File: rtl/instr_decode_reg_scoreboard.sv
// reg_scoreboard: pending-write busy vector with writeback clear, accept set and hazard lookup.
// Revision 1.0
`default_nettype none

module reg_scoreboard (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_wb_valid,
  input  logic [4:0] i_wb_rd,
  input  logic       i_set_valid,
  input  logic [4:0] i_rs1,
  input  logic [4:0] i_rs2,
  input  logic       i_use_rs2,
  input  logic [4:0] i_rd,
  output logic       o_hazard
);

  logic [31:0] r_busy;
  logic [31:0] w_clr_mask;
  logic [31:0] w_set_mask;
  logic [31:0] w_busy_clr;

  assign w_clr_mask = i_wb_valid  ? (32'd1 << i_wb_rd) : 32'd0;
  assign w_set_mask = i_set_valid ? (32'd1 << i_rd)    : 32'd0;
  // Lookups see the register as free in the cycle it retires.
  assign w_busy_clr = r_busy & ~w_clr_mask;

  assign o_hazard = w_busy_clr[i_rs1]
                  | (i_use_rs2 & w_busy_clr[i_rs2])
                  | ((i_rd != 5'd0) & w_busy_clr[i_rd]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 32'd0;
    end else begin
      r_busy <= (w_busy_clr | w_set_mask) & ~32'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/instr_decode.sv
// instr_decode: RV32 subset decoder with busy-scoreboard stall and a DEPTH-entry output FIFO.
// Revision 1.0
`default_nettype none

module instr_decode
  import instr_decode_pkg::*;
#(
  parameter int DSIZE = `DSIZE,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       instr_code,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic [DSIZE-1:0] imm,
  output logic             illegal,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [3:0]       code;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic [DSIZE-1:0] imm;
    logic             illegal;
  } entry_t;

  fmt_e       w_fmt;
  logic [3:0] w_code;
  logic       w_use_rs2;
  logic       w_hazard;
  logic       w_full;
  logic       w_push;
  logic       w_pop;
  entry_t     w_entry;
  entry_t     w_head;

  always_comb begin
    w_fmt  = FMT_X;
    w_code = c_CODE_ADD;
    unique case (instr[6:0])
      c_OP_REG: begin
        if (instr[14:12] == c_F3_ADD && instr[31:25] == c_F7_BASE) begin
          w_fmt  = FMT_R;
          w_code = c_CODE_ADD;
        end else if (instr[14:12] == c_F3_ADD && instr[31:25] == c_F7_MULDIV) begin
          w_fmt  = FMT_R;
          w_code = c_CODE_MUL;
        end
      end
      c_OP_IMM: if (instr[14:12] == c_F3_ADD) begin
        w_fmt  = FMT_I;
        w_code = c_CODE_ADDI;
      end
      c_OP_LOAD: if (instr[14:12] == c_F3_LW) begin
        w_fmt  = FMT_I;
        w_code = c_CODE_LW;
      end
      c_OP_STORE: if (instr[14:12] == c_F3_SW) begin
        w_fmt  = FMT_S;
        w_code = c_CODE_SW;
      end
      c_OP_BRANCH: if (instr[14:12] == c_F3_BNE) begin
        w_fmt  = FMT_B;
        w_code = c_CODE_BNE;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_entry         = '0;
    w_entry.code    = w_code;
    w_entry.rs1     = instr[19:15];
    w_entry.rs2     = instr[24:20];
    w_entry.illegal = (w_fmt == FMT_X);
    // Only R and I formats write a destination register.
    if (w_fmt == FMT_R || w_fmt == FMT_I) begin
      w_entry.rd = instr[11:7];
    end
    unique case (w_fmt)
      FMT_I:   w_entry.imm = {{(DSIZE-12){instr[31]}}, instr[31:20]};
      FMT_S:   w_entry.imm = {{(DSIZE-12){instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   w_entry.imm = {{(DSIZE-13){instr[31]}}, instr[31], instr[7],
                              instr[30:25], instr[11:8], 1'b0};
      default: w_entry.imm = '0;
    endcase
  end

  assign w_use_rs2 = (w_fmt == FMT_R) || (w_fmt == FMT_S) || (w_fmt == FMT_B);

  reg_scoreboard u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .i_wb_valid  (wb_valid),
    .i_wb_rd     (wb_rd),
    .i_set_valid (w_push),
    .i_rs1       (w_entry.rs1),
    .i_rs2       (w_entry.rs2),
    .i_use_rs2   (w_use_rs2),
    .i_rd        (w_entry.rd),
    .o_hazard    (w_hazard)
  );

  entry_t         r_mem [DEPTH];
  logic [PW-1:0]  r_wptr;
  logic [PW-1:0]  r_rptr;
  logic [CW-1:0]  r_count;
  logic           r_ready_en;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign out_valid = (r_count != '0);
  assign w_full    = (r_count == CW'(DEPTH));
  // r_ready_en keeps in_ready low while rst is held and for the edge it releases on.
  assign in_ready  = r_ready_en & (~w_full | (out_ready & out_valid)) & ~w_hazard;
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_ready_en <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)  r_rptr <= ptr_inc(r_rptr);
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_entry;
  end

  assign w_head     = r_mem[r_rptr];
  assign instr_code = out_valid ? w_head.code    : 4'd0;
  assign rs1        = out_valid ? w_head.rs1     : 5'd0;
  assign rs2        = out_valid ? w_head.rs2     : 5'd0;
  assign rd         = out_valid ? w_head.rd      : 5'd0;
  assign imm        = out_valid ? w_head.imm     : '0;
  assign illegal    = out_valid ? w_head.illegal : 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_instr_decode.sv
// tb_instr_decode: directed vectors with hand-computed expectations for instr_decode.
// Revision 1.0
`default_nettype none

module tb_instr_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  instr_code;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm;
  logic        illegal;
  logic        wb_valid;
  logic [4:0]  wb_rd;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  instr_decode #(.DSIZE(32), .DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .instr      (instr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .instr_code (instr_code),
    .rs1        (rs1),
    .rs2        (rs2),
    .rd         (rd),
    .imm        (imm),
    .illegal    (illegal),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string tag, input logic [3:0] code, input logic [4:0] erd,
                          input logic [31:0] eimm, input logic eill);
    chk({tag, ".valid"}, 64'(out_valid), 64'd1);
    chk({tag, ".code"},  64'(instr_code), 64'(code));
    chk({tag, ".rd"},    64'(rd), 64'(erd));
    chk({tag, ".imm"},   64'(imm), 64'(eimm));
    chk({tag, ".ill"},   64'(illegal), 64'(eill));
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; instr = 32'h0; out_ready = 1'b0;
    wb_valid = 1'b0; wb_rd = 5'd0;
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready), 64'd0);
    chk("rst_code",      64'(instr_code), 64'd0);
    chk("rst_rd",        64'(rd), 64'd0);
    chk("rst_imm",       64'(imm), 64'd0);
    chk("rst_illegal",   64'(illegal), 64'd0);
    step(); step();
    chk("rst_in_ready_clk", 64'(in_ready), 64'd0);
    rst = 1'b0;
    step();
    chk("ready_after_rst", 64'(in_ready), 64'd1);

    // ADDI x1,x0,-5 then ADD x2,x1,x1 stalled on x1
    out_ready = 1'b1; in_valid = 1'b1; instr = 32'hFFB00093; #1;
    chk("addi_ready", 64'(in_ready), 64'd1);
    step();
    instr = 32'h00108133; #1;
    chk_head("addi", 4'd2, 5'd1, 32'hFFFFFFFB, 1'b0);
    chk("addi_rs1", 64'(rs1), 64'd0);
    chk("add_hazard", 64'(in_ready), 64'd0);
    step();
    chk("add_hazard_empty", 64'(out_valid), 64'd0);
    chk("add_hazard2", 64'(in_ready), 64'd0);
    wb_valid = 1'b1; wb_rd = 5'd1; #1;
    chk("add_wb_same_cycle", 64'(in_ready), 64'd1);
    step();
    wb_valid = 1'b0;
    // SW x3,-4(x2) needs x2 retired
    instr = 32'hFE312E23; #1;
    chk_head("add", 4'd0, 5'd2, 32'h0, 1'b0);
    chk("add_rs1", 64'(rs1), 64'd1);
    chk("add_rs2", 64'(rs2), 64'd1);
    chk("sw_hazard", 64'(in_ready), 64'd0);
    wb_valid = 1'b1; wb_rd = 5'd2; #1;
    chk("sw_wb_ready", 64'(in_ready), 64'd1);
    step();
    wb_valid = 1'b0;
    instr = 32'h000E0293; #1;            // ADDI x5,x28,0
    chk_head("sw", 4'd4, 5'd0, 32'hFFFFFFFC, 1'b0);
    chk("sw_rs2", 64'(rs2), 64'd3);
    chk("sw_no_busy28", 64'(in_ready), 64'd1);
    step();
    instr = 32'hFE001CE3; #1;            // BNE x0,x0,-8
    chk_head("addi_x5", 4'd2, 5'd5, 32'h0, 1'b0);
    step();
    instr = 32'h020005B3; #1;            // MUL x11,x0,x0
    chk_head("bne", 4'd5, 5'd0, 32'hFFFFFFF8, 1'b0);
    step();
    instr = 32'h00802603; #1;            // LW x12,8(x0)
    chk_head("mul", 4'd1, 5'd11, 32'h0, 1'b0);
    step();
    instr = 32'h00000613; #1;            // ADDI x12,x0,0 (WAW)
    chk_head("lw", 4'd3, 5'd12, 32'h8, 1'b0);
    chk("waw_hazard", 64'(in_ready), 64'd0);
    wb_valid = 1'b1; wb_rd = 5'd0; #1;
    chk("wb_x0_noeffect", 64'(in_ready), 64'd0);
    wb_rd = 5'd7; #1;
    chk("wb_notbusy_noeffect", 64'(in_ready), 64'd0);
    wb_rd = 5'd12; #1;
    chk("waw_wb_ready", 64'(in_ready), 64'd1);
    step();
    wb_valid = 1'b0;
    instr = 32'h00060693; #1;            // ADDI x13,x12,0
    chk_head("addi_x12", 4'd2, 5'd12, 32'h0, 1'b0);
    chk("set_wins", 64'(in_ready), 64'd0);
    wb_valid = 1'b1; wb_rd = 5'd12; #1;
    chk("set_wins_wb", 64'(in_ready), 64'd1);
    step();
    wb_valid = 1'b0; in_valid = 1'b0; #1;
    chk_head("addi_x13", 4'd2, 5'd13, 32'h0, 1'b0);
    chk("addi_x13_rs1", 64'(rs1), 64'd12);
    step();
    chk("drained", 64'(out_valid), 64'd0);

    // Backpressure: two fit, third stalls, drain in order
    out_ready = 1'b0; in_valid = 1'b1; instr = 32'h00100313; #1;
    chk("bp_ready1", 64'(in_ready), 64'd1);
    step();
    instr = 32'h00200393; #1;
    chk_head("bp_head1", 4'd2, 5'd6, 32'h1, 1'b0);
    chk("bp_ready2", 64'(in_ready), 64'd1);
    step();
    instr = 32'h00300413; #1;
    chk("full_stall", 64'(in_ready), 64'd0);
    chk_head("bp_hold1", 4'd2, 5'd6, 32'h1, 1'b0);
    step();
    chk("full_stall2", 64'(in_ready), 64'd0);
    chk_head("bp_hold2", 4'd2, 5'd6, 32'h1, 1'b0);
    out_ready = 1'b1; #1;
    chk("full_push_pop", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0; #1;
    chk_head("bp_head2", 4'd2, 5'd7, 32'h2, 1'b0);
    step();
    chk_head("bp_head3", 4'd2, 5'd8, 32'h3, 1'b0);
    step();
    chk("bp_drained", 64'(out_valid), 64'd0);

    // Illegal pass-through, then asynchronous reset mid-stream
    out_ready = 1'b0; in_valid = 1'b1; instr = 32'h00400493;   // ADDI x9,x0,4
    step();
    instr = 32'h00000000; #1;
    chk_head("pre_ill", 4'd2, 5'd9, 32'h4, 1'b0);
    chk("ill_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0; #1;
    chk_head("illegal", 4'd0, 5'd0, 32'h0, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 64'(out_valid), 64'd0);
    chk("async_rst_in_ready",  64'(in_ready), 64'd0);
    chk("async_rst_illegal",   64'(illegal), 64'd0);
    #1 rst = 1'b0;
    step();
    chk("no_replay", 64'(out_valid), 64'd0);
    in_valid = 1'b1; instr = 32'h00048513; #1;                  // ADDI x10,x9,0
    chk("busy_cleared_by_rst", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0; out_ready = 1'b1; #1;
    chk_head("post_rst", 4'd2, 5'd10, 32'h0, 1'b0);
    chk("post_rst_rs1", 64'(rs1), 64'd9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
